// File: rtl/mux_n1_reg_pkg.sv
// Shared constants for the registered N:1 mux family: mode encodings and default sizes.
// The round-robin feature is enabled elsewhere by defining MUX_RR_EN.
package mux_pkg;

  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;

  localparam int MUX_W_DEFAULT  = 8;
  localparam int MUX_CH_DEFAULT = 4;

  // Grant/select width; never narrower than one bit.
  function automatic int mux_sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/mux_n1_reg_if.sv
// Producer/consumer bundle of the registered N:1 mux; rr_mode exists only with MUX_RR_EN.
// slave = the mux itself, master = the environment driving channels and consuming output.
interface mux_n1_reg_if #(
  parameter int W  = mux_pkg::MUX_W_DEFAULT,
  parameter int CH = mux_pkg::MUX_CH_DEFAULT
);
  import mux_pkg::*;

  localparam int SW = mux_sel_width(CH);

  logic [CH*W-1:0] mux_in;
  logic [CH-1:0]   mux_in_valid;
  logic [CH-1:0]   mux_in_ready;
  logic [SW-1:0]   sel;
`ifdef MUX_RR_EN
  logic            rr_mode;
`endif
  logic [W-1:0]    mux_out;
  logic            mux_out_valid;
  logic            mux_out_ready;
  logic [SW-1:0]   grant;

`ifdef MUX_RR_EN
  modport slave (
    input  mux_in, mux_in_valid, sel, rr_mode, mux_out_ready,
    output mux_in_ready, mux_out, mux_out_valid, grant
  );
  modport master (
    output mux_in, mux_in_valid, sel, rr_mode, mux_out_ready,
    input  mux_in_ready, mux_out, mux_out_valid, grant
  );
`else
  modport slave (
    input  mux_in, mux_in_valid, sel, mux_out_ready,
    output mux_in_ready, mux_out, mux_out_valid, grant
  );
  modport master (
    output mux_in, mux_in_valid, sel, mux_out_ready,
    input  mux_in_ready, mux_out, mux_out_valid, grant
  );
`endif

endinterface

// File: rtl/mux_n1_reg_rr_pick.sv
// Combinational wrap-around priority scan: first valid channel at or above ptr_i, else lowest.
// Compiled in only when MUX_RR_EN is defined.
`ifdef MUX_RR_EN
module mux_rr_pick #(
  parameter int CH = 4,
  parameter int SW = 2
) (
  input  logic [CH-1:0] valid_i,
  input  logic [SW-1:0] ptr_i,
  output logic          found_o,
  output logic [SW-1:0] idx_o
);

  logic [CH-1:0] upper_mask;
  logic [CH-1:0] upper_valid;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_mask
      assign upper_mask[gi] = (SW'(gi) >= ptr_i);
    end
  endgenerate

  assign upper_valid = valid_i & upper_mask;

  // Lowest channel overall is the wrap fallback; any hit at/above ptr overrides it.
  always_comb begin
    found_o = |valid_i;
    idx_o   = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (valid_i[i]) idx_o = SW'(i);
    end
    for (int i = CH - 1; i >= 0; i--) begin
      if (upper_valid[i]) idx_o = SW'(i);
    end
  end

endmodule
`endif

// File: rtl/mux_n1_reg.sv
// Registered N:1 multiplexer with per-channel valid/ready and a one-deep output register.
// Define MUX_RR_EN to add the rr_mode input, the round-robin pointer and picker.
module mux_n1_reg
  import mux_pkg::*;
#(
  parameter int W  = MUX_W_DEFAULT,
  parameter int CH = MUX_CH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  mux_n1_reg_if.slave bus
);

  localparam int SW = mux_sel_width(CH);

  logic [W-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] grant_q, grant_d;

  logic          load;
  logic [CH-1:0] ready_fixed;
  logic [CH-1:0] ready_all;
  logic [CH-1:0] take;
  logic          xfer;
  logic [SW-1:0] xfer_idx;
  logic [W-1:0]  xfer_data;

  assign load = !valid_q || bus.mux_out_ready;

  // An out-of-range sel never matches any channel index, so all ready bits stay low.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_fixed
      assign ready_fixed[gi] = load && (bus.sel == SW'(gi));
    end
  endgenerate

`ifdef MUX_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  logic          rr_sel;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [CH-1:0] ready_rr;

  assign rr_sel = (bus.rr_mode == MUX_MODE_RR);

  mux_rr_pick #(
    .CH (CH),
    .SW (SW)
  ) u_pick (
    .valid_i (bus.mux_in_valid),
    .ptr_i   (ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_rr
      assign ready_rr[gi] = load && rr_found && (rr_idx == SW'(gi));
    end
  endgenerate

  assign ready_all = rr_sel ? ready_rr : ready_fixed;
  assign xfer_idx  = rr_sel ? rr_idx : bus.sel;

  // Pointer moves past the winner only on round-robin transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (rr_sel && xfer) begin
      ptr_d = (xfer_idx == SW'(CH - 1)) ? '0 : xfer_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ready_all = ready_fixed;
  assign xfer_idx  = bus.sel;
`endif

  assign take = ready_all & bus.mux_in_valid;
  assign xfer = |take;

  // take is at most one-hot, so an AND-OR select needs no range check on the index.
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (take[i]) xfer_data = xfer_data | bus.mux_in[i*W +: W];
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    grant_d = grant_q;
    if (xfer) begin
      out_d   = xfer_data;
      grant_d = xfer_idx;
      valid_d = 1'b1;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign bus.mux_in_ready  = ready_all;
  assign bus.mux_out       = out_q;
  assign bus.mux_out_valid = valid_q;
  assign bus.grant         = grant_q;

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ready_all));

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (valid_q && !bus.mux_out_ready) |=> ($stable(out_q) && $stable(grant_q)));

endmodule

// File: tb/tb_mux_n1_reg.sv
// Directed bench for mux_n1_reg (CH=4 main instance, CH=3 instance for out-of-range sel).
// Round-robin scenarios are included when MUX_RR_EN is defined.
module tb_mux_n1_reg;
  import mux_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rr_on = 1'b0;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mux_n1_reg_if #(.W(W), .CH(CH)) bus ();
  mux_n1_reg_if #(.W(W), .CH(3))  bus3 ();

`ifdef MUX_RR_EN
  assign bus.rr_mode  = rr_on;
  assign bus3.rr_mode = MUX_MODE_FIXED;
`endif

  mux_n1_reg #(.W(W), .CH(CH)) dut (.clk(clk), .rst(rst), .bus(bus));
  mux_n1_reg #(.W(W), .CH(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: output slot contents and rotation pointer, derived from the transfer rules.
  logic [W-1:0] m_out;
  logic         m_valid;
  int           m_grant;
  int           m_ptr;

  function automatic logic [CH-1:0] model_ready();
    logic [CH-1:0] r;
    r = '0;
    if (m_valid && !bus.mux_out_ready) return r;
    if (rr_on) begin
      for (int k = 0; k < CH; k++) begin
        if (bus.mux_in_valid[(m_ptr + k) % CH]) begin
          r[(m_ptr + k) % CH] = 1'b1;
          return r;
        end
      end
    end else if (int'(bus.sel) < CH) begin
      r[bus.sel] = 1'b1;
    end
    return r;
  endfunction

  function automatic int model_taker();
    logic [CH-1:0] t;
    t = model_ready() & bus.mux_in_valid;
    for (int i = 0; i < CH; i++) if (t[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out   <= '0;
      m_valid <= 1'b0;
      m_grant <= 0;
      m_ptr   <= 0;
    end else if (model_taker() >= 0) begin
      m_out   <= bus.mux_in[model_taker()*W +: W];
      m_grant <= model_taker();
      m_valid <= 1'b1;
      m_ptr   <= rr_on ? (model_taker() + 1) % CH : m_ptr;
    end else if (!m_valid || bus.mux_out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("cyc_ready", bus.mux_in_ready, model_ready());
      chk("cyc_valid", bus.mux_out_valid, m_valid);
      chk("cyc_out",   bus.mux_out, m_out);
      chk("cyc_grant", bus.grant, m_grant);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed fixed-mode vectors with literal expected state after the edge.
  logic [1:0] v_sel   [8] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
  logic [3:0] v_valid [8] = '{4'b1111, 4'b1111, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
  logic       v_ordy  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] e_out   [8] = '{8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h02, 8'h3C, 8'h3C};
  logic [1:0] e_grant [8] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2};
  logic       e_valid [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    bus.mux_in        = {8'h04, 8'hA5, 8'h02, 8'h01};
    bus.mux_in_valid  = 4'b0100;
    bus.sel           = 2'd2;
    bus.mux_out_ready = 1'b1;
    bus3.mux_in        = {8'h33, 8'h22, 8'h11};
    bus3.mux_in_valid  = 3'b000;
    bus3.sel           = 2'd0;
    bus3.mux_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_ready", bus.mux_in_ready, 4'b0100);
    chk("rst_valid", bus.mux_out_valid, 0);
    chk("rst_out",   bus.mux_out, 0);
    chk("rst_grant", bus.grant, 0);

    step();
    chk("t1_out",   bus.mux_out, 8'hA5);
    chk("t1_grant", bus.grant, 2);
    chk("t1_valid", bus.mux_out_valid, 1);

    // Back-pressure for three cycles, then consume and reload in one cycle.
    bus.mux_out_ready = 1'b0;
    bus.mux_in[23:16] = 8'h3C;
    #1 chk("bp_ready0", bus.mux_in_ready, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      step();
      $display("bp cycle %0d: out=%0h grant=%0d ready=%b", c, bus.mux_out, bus.grant, bus.mux_in_ready);
      chk("bp_out",   bus.mux_out, 8'hA5);
      chk("bp_grant", bus.grant, 2);
      chk("bp_valid", bus.mux_out_valid, 1);
      chk("bp_ready", bus.mux_in_ready, 4'b0000);
    end
    bus.mux_out_ready = 1'b1;
    #1 chk("bp_release_ready", bus.mux_in_ready, 4'b0100);
    step();
    chk("bp_reload_out", bus.mux_out, 8'h3C);

    for (int v = 0; v < 8; v++) begin
      bus.sel = v_sel[v];
      bus.mux_in_valid = v_valid[v];
      bus.mux_out_ready = v_ordy[v];
      step();
      $display("vec %0d: sel=%0d valid=%b ordy=%b -> out=%0h grant=%0d ovalid=%b",
               v, v_sel[v], v_valid[v], v_ordy[v], bus.mux_out, bus.grant, bus.mux_out_valid);
      chk("vec_out",   bus.mux_out, e_out[v]);
      chk("vec_grant", bus.grant, e_grant[v]);
      chk("vec_valid", bus.mux_out_valid, e_valid[v]);
    end

`ifdef MUX_RR_EN
    rr_on = 1'b1;
    bus.mux_in = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    bus.mux_in_valid = 4'b1111;
    bus.mux_out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      step();
      $display("rr burst %0d: grant=%0d out=%0h", g, bus.grant, bus.mux_out);
      chk("rr_grant", bus.grant, g % 4);
      chk("rr_out",   bus.mux_out, 8'hD0 + (g % 4));
    end
    bus.mux_in_valid = 4'b0100;
    step();
    chk("rr_ptr3_grant", bus.grant, 2);
    bus.mux_in_valid = 4'b0011;
    step();
    chk("rr_wrap_grant", bus.grant, 0);
    step();
    chk("rr_next_grant", bus.grant, 1);
    bus.mux_in_valid = 4'b1111;
    step();
    step();
    chk("rr_pre_rst_grant", bus.grant, 3);
`else
    bus.mux_in = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    bus.mux_in_valid = 4'b1111;
    bus.mux_out_ready = 1'b1;
    bus.sel = 2'd3;
    step();
    step();
    chk("fx_pre_rst_grant", bus.grant, 3);
`endif

    // Asynchronous reset mid-burst clears the output slot without a clock edge.
    bus.sel = 2'd1;
    #2 rst = 1'b1;
    #1;
    $display("async rst: valid=%b out=%0h grant=%0d", bus.mux_out_valid, bus.mux_out, bus.grant);
    chk("arst_valid", bus.mux_out_valid, 0);
    chk("arst_out",   bus.mux_out, 0);
    chk("arst_grant", bus.grant, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
`ifdef MUX_RR_EN
    chk("post_rst_grant", bus.grant, 0);
    chk("post_rst_out",   bus.mux_out, 8'hD0);
`else
    chk("post_rst_grant", bus.grant, 1);
    chk("post_rst_out",   bus.mux_out, 8'hD1);
`endif
    chk("post_rst_valid", bus.mux_out_valid, 1);

    // CH=3 instance: sel=3 is out of range.
    bus3.mux_in_valid = 3'b111;
    bus3.sel = 2'd0;
    step();
    chk("ch3_out",   bus3.mux_out, 8'h11);
    chk("ch3_valid", bus3.mux_out_valid, 1);
    bus3.sel = 2'd3;
    #1 chk("ch3_sel3_ready", bus3.mux_in_ready, 3'b000);
    step();
    $display("ch3 sel=3: ready=%b valid=%b out=%0h", bus3.mux_in_ready, bus3.mux_out_valid, bus3.mux_out);
    chk("ch3_sel3_valid", bus3.mux_out_valid, 0);
    chk("ch3_sel3_out",   bus3.mux_out, 8'h11);
    step();
    chk("ch3_sel3_hold", bus3.mux_out_valid, 0);
    chk("ch3_sel3_ready2", bus3.mux_in_ready, 3'b000);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n1_reg.md
# mux_n1_reg

Parametrised, registered N:1 multiplexer with valid/ready handshakes on every input channel and on the output. Generalises the team's 2:1 mux to CH channels of W bits. Adds a one-deep output register, back-pressure, and an optional round-robin mode that selects among valid channels automatically. Sits between multiple producers and a single shared consumer.

## Interface
- `W`, 8, data width per channel (≥1)
- `CH`, 4, number of input channels (≥2; need not be a power of two)
- `SW`, $clog2(CH), select/grant width (derived; do not override)
- `clk`  input  1  clock; all state on posedge
- `rst`  input  1  reset, asynchronous, active-high
- `mux_in`  input  CH*W  channel data; channel i at [i*W +: W]
- `mux_in_valid`  input  CH  per-channel valid
- `mux_in_ready`  output  CH  per-channel ready (combinational)
- `sel`  input  SW  channel index used in fixed mode
- `rr_mode`  input  1  0 = fixed (use `sel`), 1 = round-robin (present only with MUX_RR_EN)
- `mux_out`  output  W  registered output data
- `mux_out_valid`  output  1  output register holds data
- `mux_out_ready`  input  1  consumer accepts `mux_out`
- `grant`  output  SW  index of channel whose data is in `mux_out`

## Operation
- `load = !mux_out_valid || mux_out_ready`. The output register accepts a new word only when `load` is high.
- Fixed mode:
  - `mux_in_ready[i] = load && (sel == i)`.
  - `sel >= CH`: all ready low, nothing accepted.
- Round-robin mode:
  - Candidate is the first i with `mux_in_valid[i]`, scanning from pointer `ptr` upward with wrap at CH.
  - Only the candidate sees `mux_in_ready` high (when `load`).
  - No valid channel: all ready low and `ptr` holds.
- Transfer: channel i transfers when `mux_in_valid[i] && mux_in_ready[i]`. On the next edge:
  - `mux_out <= mux_in[i]`, `grant <= i`, `mux_out_valid <= 1`.
  - In round-robin mode, `ptr <= (i+1) mod CH`.
- `load` high with no transfer: `mux_out_valid <= 0`. `mux_out` and `grant` hold their stale values.
- Output stable rule: while `mux_out_valid && !mux_out_ready`, `mux_out` and `grant` must not change.
- Mode or `sel` changes take effect on the same cycle's ready computation. `ptr` is unaffected by fixed-mode transfers.
- At most one input transfer per cycle. An output consume and a new input transfer may occur in the same cycle.

## Timing
- Reset values: `mux_out = 0`, `mux_out_valid = 0`, `grant = 0`, `ptr = 0`. `mux_in_ready` is combinationally 0 for `sel >= CH` and otherwise follows `load`. With `mux_out_valid = 0`, `load` is 1.
- Reset asserted mid-operation discards the held word immediately, without waiting for a clock edge.
- Latency: input transfer at edge n means `mux_out_valid` is high after edge n.
- Throughput: one word per cycle while `mux_out_ready` stays high.
- `mux_in_ready` has a combinational path from `mux_out_ready`, `sel`, `rr_mode` and `mux_in_valid`. Producers must not make `mux_in_valid` depend on `mux_in_ready`.

## Configuration
- `MUX_RR_EN` defined: the `rr_mode` port, the `ptr` register and the round-robin picker are compiled in.
- `MUX_RR_EN` undefined:
  - The `rr_mode` port is absent and the block is fixed-mode only.
  - No pointer state exists.
  - All other behaviour is identical.

## Structure
- Shared package `mux_pkg`:
  - Mode constants `MUX_MODE_FIXED = 1'b0` and `MUX_MODE_RR = 1'b1`.
  - Shared default parameter values for W and CH.
- Sub-module `mux_rr_pick` (compiled only under `MUX_RR_EN`):
  - Inputs: CH-bit valid vector and SW-bit pointer.
  - Outputs: `found` and the SW-bit index.
  - Purely combinational, wrap-around priority scan.

## Test plan
1. Reset release, CH=4, W=8, fixed mode, `sel=2`, `mux_in_valid=4'b0100`, channel 2 data `0xA5`, `mux_out_ready=1` → `mux_in_ready=4'b0100`; after one edge `mux_out=0xA5`, `grant=2`, `mux_out_valid=1`.
2. Back-pressure: hold `mux_out_ready=0` for 3 cycles with `mux_out_valid=1` → `mux_in_ready=0`, `mux_out` and `grant` stable; on ready=1, consume and load the next word in the same cycle.
3. Fixed mode, `sel=3` on CH=3 → no ready asserted, no transfer, `mux_out_valid` falls after consume.
4. Round-robin (`MUX_RR_EN`), all four valid continuously, `mux_out_ready=1` → grants 0,1,2,3,0 on consecutive cycles.
5. Round-robin, `ptr=3`, valid = `4'b0011` → grant 0 (wrap), then `ptr=1`, next grant 1.
6. Assert `rst` asynchronously mid-burst → `mux_out_valid`, `mux_out`, `grant` go 0 immediately; first post-reset round-robin grant starts from channel 0.
